// File: rtl/fp_pkg.sv
// fp_pkg -- shared IEEE-754 single-precision constants and types used by the
// twiddle multiplier, the float adder and the butterfly top.
//   EXP_W / MAN_W : exponent and stored-mantissa field widths
//   FP_BIAS       : exponent bias
//   FP_EXP_MAX    : all-ones exponent (inf/NaN)
//   FP_QNAN       : canonical quiet NaN returned for 0 * inf
//   fp_flags_t    : result sign plus operand-class flags carried down the pipe
package fp_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int FP_BIAS = 127;

   localparam logic [EXP_W-1:0] FP_EXP_MAX = 8'hFF;
   localparam logic [31:0]      FP_QNAN    = 32'h7FC0_0000;

   typedef struct packed {
      logic sign;     // sign of the product
      logic zero;     // either operand has exponent 0 (denormals count as zero)
      logic special;  // either operand has exponent 255 (inf or NaN)
   } fp_flags_t;

endpackage

// File: rtl/fp_norm_pack.sv
// fp_norm_pack -- combinational normalize/pack of a 24x24 mantissa product.
// Truncates (no rounding) and flushes underflow to +0.
//   p     : 48-bit unsigned mantissa product (1.x * 1.x, so p[47:46] != 0)
//   e     : biased result exponent before normalization, signed 10-bit
//   flags : result sign and operand-class flags
//   word  : packed IEEE-754 single result
module fp_norm_pack
   import fp_pkg::*;
(
   input  logic [47:0]       p,
   input  logic signed [9:0] e,
   input  fp_flags_t         flags,
   output logic [31:0]       word
);

   logic signed [9:0]  e_adj;
   logic [MAN_W-1:0]   mant;
   logic               unused_low;

   // Bits below the truncation point never influence the result.
   assign unused_low = ^p[22:0];

   // Resolve class flags first, then saturate the exponent range.
   function automatic logic [31:0] sat_pack(input fp_flags_t f,
                                            input logic signed [9:0] ex,
                                            input logic [MAN_W-1:0] m);
      logic [31:0] r;
      if (f.zero && f.special)
         r = FP_QNAN;
      else if (f.special)
         r = {f.sign, FP_EXP_MAX, {MAN_W{1'b0}}};
      else if (f.zero)
         r = 32'h0000_0000;
      else if (ex >= 10'sd255)
         r = {f.sign, FP_EXP_MAX, {MAN_W{1'b0}}};
      else if (ex <= 10'sd0)
         r = 32'h0000_0000;
      else
         r = {f.sign, ex[EXP_W-1:0], m};
      return r;
   endfunction

   // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
   always_comb begin
      e_adj = e;
      mant  = p[45:23];
      if (p[47]) begin
         e_adj = e + 10'sd1;
         mant  = p[46:24];
      end
   end

   assign word = sat_pack(flags, e_adj, mant);

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe -- three-stage pipelined IEEE-754 single multiplier (B * W) for the
// FFT twiddle path, with a valid/ready handshake and a pass-through tag.
// All stages advance together when the output is free or being consumed.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready = pipeline advance)
//   a, b, in_tag          : operands and side-band tag
//   out_valid / out_ready : result handshake
//   product, out_tag      : result and its tag
module fmul_pipe
   import fp_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      product,
   output logic [TAG_W-1:0] out_tag
);

   logic adv;

   logic                vld_p0, vld_p1, vld_p2;

   logic [EXP_W-1:0]    ea_p0, eb_p0;
   logic [MAN_W:0]      ma_p0, mb_p0;
   fp_flags_t           flags_p0;
   logic [TAG_W-1:0]    tag_p0;

   logic [47:0]         p_p1;
   logic signed [9:0]   e_p1;
   fp_flags_t           flags_p1;
   logic [TAG_W-1:0]    tag_p1;

   logic [31:0]         word_p1;
   logic [31:0]         product_p2;
   logic [TAG_W-1:0]    tag_p2;

   logic                a_zero, b_zero, a_spec, b_spec;

   // Bubbles are kept: the whole pipe moves whenever the output slot frees.
   assign adv      = out_ready | ~vld_p2;
   assign in_ready = adv;

   assign a_zero = (a[30:23] == '0);
   assign b_zero = (b[30:23] == '0);
   assign a_spec = (a[30:23] == FP_EXP_MAX);
   assign b_spec = (b[30:23] == FP_EXP_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (adv) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         // S1: operand fields and class flags
         ea_p0    <= a[30:23];
         eb_p0    <= b[30:23];
         ma_p0    <= {1'b1, a[22:0]};
         mb_p0    <= {1'b1, b[22:0]};
         flags_p0 <= '{sign:    a[31] ^ b[31],
                       zero:    a_zero | b_zero,
                       special: a_spec | b_spec};
         tag_p0   <= in_tag;
         // S2: mantissa product and unnormalized biased exponent
         p_p1     <= 48'(ma_p0) * 48'(mb_p0);
         e_p1     <= $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0})
                     - $signed(10'(FP_BIAS));
         flags_p1 <= flags_p0;
         tag_p1   <= tag_p0;
      end
   end

   fp_norm_pack u_norm_pack (
      .p     (p_p1),
      .e     (e_p1),
      .flags (flags_p1),
      .word  (word_p1)
   );

   // S3: packed result register, cleared so nothing stale is visible after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_p2 <= '0;
         tag_p2     <= '0;
      end else if (adv) begin
         product_p2 <= word_p1;
         tag_p2     <= tag_p1;
      end
   end

   assign out_valid = vld_p2;
   assign product   = product_p2;
   assign out_tag   = tag_p2;

endmodule
